// File: rtl/boot_loader_pkg.sv
// Shared encodings for the byte-serial instruction-memory boot loader.
// Frame: LEN_LO, LEN_HI, N*4 payload bytes, XOR checksum.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam int FRAME_BYTES_PER_WORD = 4;
  localparam int HDR_W = 16;

endpackage

// File: rtl/byte_word_packer.sv
// Shifts little-endian bytes into 32-bit words and emits a
// registered one-cycle word strobe with the completed word.
module byte_word_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        word_vld,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX =
    2'(FRAME_BYTES_PER_WORD - 1);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    sh_d   = sh_q;
    idx_d  = idx_q;
    vld_d  = 1'b0;
    word_d = word_q;
    if (clear) begin
      sh_d  = '0;
      idx_d = '0;
    end else if (byte_vld) begin
      if (idx_q == LAST_IDX) begin
        word_d = {byte_in, sh_q};
        vld_d  = 1'b1;
        idx_d  = '0;
      end else begin
        // Oldest byte drifts down to bits 7:0.
        sh_d  = {byte_in, sh_q[23:8]};
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      sh_q   <= sh_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      word_q <= word_d;
    end
  end

  assign word_vld = vld_q;
  assign word     = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Frame-parsing boot loader: writes the program image into imem
// and releases cpu_reset once the checksum verifies.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [HDR_W:0] CAP_HDR =
    (HDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CAP_W =
    (ADDR_W+1)'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [HDR_W-1:0]    len_q, len_d;
  logic [HDR_W-1:0]    widx_q, widx_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [7:0]          xor_q, xor_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic             accept;
  logic [HDR_W-1:0] hdr;
  logic             pk_vld;
  logic [31:0]      pk_word;

  assign rx_ready = (state_q != S_DONE) &&
                    (state_q != S_ERROR);
  assign accept   = rx_valid && rx_ready;
  assign hdr      = {rx_data, len_lo_q};

  byte_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q != S_DATA),
    .byte_vld (accept && (state_q == S_DATA)),
    .byte_in  (rx_data),
    .word_vld (pk_vld),
    .word     (pk_word)
  );

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    xor_d     = xor_q;
    addr_d    = addr_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    words_d   = words_q;
    if (pk_vld && (words_q != CAP_W))
      words_d = words_q + 1'b1;
    if (accept) begin
      unique case (state_q)
        S_LEN_LO: begin
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d  = hdr;
          widx_d = '0;
          bidx_d = '0;
          xor_d  = '0;
          if (hdr == '0) begin
            state_d = S_CSUM;
          end else if ({1'b0, hdr} > CAP_HDR) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          xor_d  = xor_q ^ rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'(FRAME_BYTES_PER_WORD - 1)) begin
            // Address registers alongside the packer's word.
            addr_d = widx_q[ADDR_W-1:0];
            widx_d = widx_q + 1'b1;
            if (widx_q == len_q - 1'b1)
              state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_data == xor_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LEN_LO;
      len_lo_q  <= '0;
      len_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      xor_q     <= '0;
      addr_q    <= '0;
      words_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      widx_q    <= widx_d;
      bidx_q    <= bidx_d;
      xor_q     <= xor_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_we      = pk_vld;
  assign imem_addr    = addr_q;
  assign imem_wdata   = pk_word;
  assign cpu_reset    = cpu_rst_q;
  assign load_done    = done_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule
